// File: rtl/mem_pkg.sv
// Shared definitions for the memory arbiter: RV64 load/store funct3
// encodings, the response-owner enum and the natural-alignment check.
package mem_pkg;

  localparam logic [2:0] MEMOP_B  = 3'b000;
  localparam logic [2:0] MEMOP_H  = 3'b001;
  localparam logic [2:0] MEMOP_W  = 3'b010;
  localparam logic [2:0] MEMOP_D  = 3'b011;
  localparam logic [2:0] MEMOP_BU = 3'b100;
  localparam logic [2:0] MEMOP_HU = 3'b101;
  localparam logic [2:0] MEMOP_WU = 3'b110;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

  // Access size comes from funct3[1:0]; 3'b111 falls into the d case.
  function automatic logic misaligned(input logic [2:0] memop, input logic [2:0] off);
    case (memop[1:0])
      MEMOP_H[1:0]: return off[0];
      MEMOP_W[1:0]: return |off[1:0];
      MEMOP_D[1:0]: return |off;
      default:      return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ld_align.sv
// Load-data aligner: picks the addressed lane out of a 64-bit SRAM word
// and sign- or zero-extends it according to the load funct3.
module ld_align
  import mem_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [63:0]     rdata,
  input  logic [2:0]      off,
  input  logic [2:0]      memop,
  output logic [XLEN-1:0] result
);

  logic [63:0] shifted;

  function automatic logic [XLEN-1:0] ext8(input logic [7:0] v, input logic sgn);
    return {{(XLEN-8){sgn & v[7]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] ext16(input logic [15:0] v, input logic sgn);
    return {{(XLEN-16){sgn & v[15]}}, v};
  endfunction

  function automatic logic [XLEN-1:0] ext32(input logic [31:0] v, input logic sgn);
    return {{(XLEN-32){sgn & v[31]}}, v};
  endfunction

  // Move the addressed byte to lane 0, then extend by access size.
  always_comb begin
    shifted = rdata >> {off, 3'b000};
    case (memop)
      MEMOP_B:  result = ext8(shifted[7:0], 1'b1);
      MEMOP_BU: result = ext8(shifted[7:0], 1'b0);
      MEMOP_H:  result = ext16(shifted[15:0], 1'b1);
      MEMOP_HU: result = ext16(shifted[15:0], 1'b0);
      MEMOP_W:  result = ext32(shifted[31:0], 1'b1);
      MEMOP_WU: result = ext32(shifted[31:0], 1'b0);
      default:  result = shifted[XLEN-1:0];
    endcase
  end

endmodule

// File: rtl/mem_arb.sv
// Single-port SRAM arbiter between instruction fetch and load/store.
// One grant per cycle, 1-cycle response latency, byte-strobed stores,
// extended loads, misaligned LS accesses rejected without a memory access.
// Build option MEM_ARB_RR_EN: round-robin arbitration instead of fixed LS
// priority with a fetch starvation guard.
module mem_arb
  import mem_pkg::*;
#(
  parameter int XLEN       = 64,
  parameter int DEPTH_LOG2 = 8,
  parameter int STARVE_MAX = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  if_req_i,
  input  logic [XLEN-1:0]       if_addr_i,
  output logic                  if_gnt_o,
  output logic                  if_rvalid_o,
  output logic [31:0]           if_rdata_o,
  input  logic                  ls_req_i,
  input  logic                  ls_we_i,
  input  logic [2:0]            ls_memop_i,
  input  logic [XLEN-1:0]       ls_addr_i,
  input  logic [XLEN-1:0]       ls_wdata_i,
  output logic                  ls_gnt_o,
  output logic                  ls_rvalid_o,
  output logic [XLEN-1:0]       ls_rdata_o,
  output logic                  ls_err_o,
  output logic                  mem_en_o,
  output logic                  mem_we_o,
  output logic [DEPTH_LOG2-1:0] mem_addr_o,
  output logic [63:0]           mem_wdata_o,
  output logic [7:0]            mem_wstrb_o,
  input  logic [63:0]           mem_rdata_i
);

  logic [2:0]      ls_off;
  logic            ls_mis;
  logic [XLEN-1:0] ld_data;

  owner_e      owner_p1;
  logic [2:0]  memop_p1;
  logic [2:0]  off_p1;
  logic        err_p1;
  logic        we_p1;
  logic        if_hi_p1;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr_i[XLEN-1:DEPTH_LOG2+3], if_addr_i[1:0],
                              ls_addr_i[XLEN-1:DEPTH_LOG2+3]};

  assign ls_off = ls_addr_i[2:0];
  assign ls_mis = misaligned(ls_memop_i, ls_off);

  function automatic logic [63:0] store_lanes(input logic [2:0] memop, input logic [63:0] d);
    case (memop[1:0])
      MEMOP_B[1:0]: return {8{d[7:0]}};
      MEMOP_H[1:0]: return {4{d[15:0]}};
      MEMOP_W[1:0]: return {2{d[31:0]}};
      default:      return d;
    endcase
  endfunction

  function automatic logic [7:0] store_strb(input logic [2:0] memop, input logic [2:0] off);
    case (memop[1:0])
      MEMOP_B[1:0]: return 8'h01 << off;
      MEMOP_H[1:0]: return 8'h03 << off;
      MEMOP_W[1:0]: return 8'h0F << off;
      default:      return 8'hFF;
    endcase
  endfunction

`ifdef MEM_ARB_RR_EN
  owner_e rr_ptr;

  // Round-robin pointer: after any grant, the other requester is favoured.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr <= OWN_IF;
    end else if (if_gnt_o) begin
      rr_ptr <= OWN_LS;
    end else if (ls_gnt_o) begin
      rr_ptr <= OWN_IF;
    end
  end

  // Grant: a lone requester wins; on a tie the pointed-at requester wins.
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (rst_n) begin
      if (if_req_i && ls_req_i) begin
        if (rr_ptr == OWN_IF) if_gnt_o = 1'b1;
        else                  ls_gnt_o = 1'b1;
      end else begin
        if_gnt_o = if_req_i;
        ls_gnt_o = ls_req_i;
      end
    end
  end
`else
  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  logic [STARVE_W-1:0] starve_cnt;

  // Count LS grants taken while fetch is waiting; any fetch grant or an
  // idle fetch port restarts the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= '0;
    end else if (!if_req_i || if_gnt_o) begin
      starve_cnt <= '0;
    end else if (ls_gnt_o) begin
      starve_cnt <= starve_cnt + STARVE_W'(1);
    end
  end

  // Grant: LS first, unless fetch has already waited STARVE_MAX LS grants.
  always_comb begin
    if_gnt_o = 1'b0;
    ls_gnt_o = 1'b0;
    if (rst_n) begin
      if (ls_req_i && !(if_req_i && (starve_cnt == STARVE_W'(STARVE_MAX)))) begin
        ls_gnt_o = 1'b1;
      end else begin
        if_gnt_o = if_req_i;
      end
    end
  end
`endif

  // Drive the SRAM from the winner; a misaligned LS grant leaves it idle.
  always_comb begin
    mem_en_o    = 1'b0;
    mem_we_o    = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    mem_wstrb_o = '0;
    if (if_gnt_o) begin
      mem_en_o   = 1'b1;
      mem_addr_o = if_addr_i[DEPTH_LOG2+2:3];
    end else if (ls_gnt_o && !ls_mis) begin
      mem_en_o   = 1'b1;
      mem_addr_o = ls_addr_i[DEPTH_LOG2+2:3];
      if (ls_we_i) begin
        mem_we_o    = 1'b1;
        mem_wdata_o = store_lanes(ls_memop_i, ls_wdata_i[63:0]);
        mem_wstrb_o = store_strb(ls_memop_i, ls_off);
      end
    end
  end

  // ---- stage p1: response owner captured at grant ----
  // Owner decides who sees rvalid next cycle; reset drops any pending response.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_p1 <= OWN_NONE;
    end else if (if_gnt_o) begin
      owner_p1 <= OWN_IF;
    end else if (ls_gnt_o) begin
      owner_p1 <= OWN_LS;
    end else begin
      owner_p1 <= OWN_NONE;
    end
  end

  // Access attributes needed to shape the response; only read under owner_p1.
  always_ff @(posedge clk) begin
    if (ls_gnt_o) begin
      memop_p1 <= ls_memop_i;
      off_p1   <= ls_off;
      err_p1   <= ls_mis;
      we_p1    <= ls_we_i;
    end
    if (if_gnt_o) begin
      if_hi_p1 <= if_addr_i[2];
    end
  end

  ld_align #(.XLEN(XLEN)) u_ld_align (
    .rdata  (mem_rdata_i),
    .off    (off_p1),
    .memop  (memop_p1),
    .result (ld_data)
  );

  assign if_rvalid_o = (owner_p1 == OWN_IF);
  assign if_rdata_o  = !if_rvalid_o ? 32'h0 :
                       (if_hi_p1 ? mem_rdata_i[63:32] : mem_rdata_i[31:0]);
  assign ls_rvalid_o = (owner_p1 == OWN_LS);
  assign ls_err_o    = ls_rvalid_o & err_p1;
  assign ls_rdata_o  = (ls_rvalid_o && !err_p1 && !we_p1) ? ld_data : '0;

endmodule

// File: tb/tb_mem_arb.sv
// Bench for mem_arb: directed scenarios plus randomized traffic against a
// byte-addressed reference memory and a rule-level arbitration model.
// Build with +define+MEM_ARB_RR_EN to exercise the round-robin variant.
module tb_mem_arb;
  import mem_pkg::*;

  localparam int XLEN       = 64;
  localparam int DEPTH_LOG2 = 8;
  localparam int STARVE_MAX = 3;
  localparam int NWORDS     = 1 << DEPTH_LOG2;
  localparam int NBYTES     = NWORDS * 8;

  logic                  clk = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  if_req_i = 1'b0;
  logic [XLEN-1:0]       if_addr_i = '0;
  logic                  if_gnt_o, if_rvalid_o;
  logic [31:0]           if_rdata_o;
  logic                  ls_req_i = 1'b0, ls_we_i = 1'b0;
  logic [2:0]            ls_memop_i = '0;
  logic [XLEN-1:0]       ls_addr_i = '0, ls_wdata_i = '0;
  logic                  ls_gnt_o, ls_rvalid_o, ls_err_o;
  logic [XLEN-1:0]       ls_rdata_o;
  logic                  mem_en_o, mem_we_o;
  logic [DEPTH_LOG2-1:0] mem_addr_o;
  logic [63:0]           mem_wdata_o;
  logic [7:0]            mem_wstrb_o;
  logic [63:0]           mem_rdata_i = '0;

  mem_arb #(.XLEN(XLEN), .DEPTH_LOG2(DEPTH_LOG2), .STARVE_MAX(STARVE_MAX)) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_memop_i(ls_memop_i),
    .ls_addr_i(ls_addr_i), .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o), .ls_err_o(ls_err_o),
    .mem_en_o(mem_en_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_wstrb_o(mem_wstrb_o), .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  // SRAM behavioural model (1-cycle read latency), plus a preload port.
  logic [63:0]           sram [NWORDS];
  logic                  poke_en = 1'b0;
  logic [DEPTH_LOG2-1:0] poke_idx = '0;
  logic [63:0]           poke_val = '0;

  always @(posedge clk) begin
    if (poke_en) begin
      sram[poke_idx] <= poke_val;
    end else if (mem_en_o) begin
      if (mem_we_o) begin
        for (int i = 0; i < 8; i++) begin
          if (mem_wstrb_o[i]) sram[mem_addr_o][8*i +: 8] <= mem_wdata_o[8*i +: 8];
        end
      end else begin
        mem_rdata_i <= sram[mem_addr_o];
      end
    end
  end

  // Reference state
  logic [7:0]  ref_b [NBYTES];
  bit          exp_if_v, exp_ls_v, exp_ls_e;
  logic [31:0] exp_if_d;
  logic [63:0] exp_ls_d;
  int          ls_streak;
  bit          favor_if;
  bit          saw_if, saw_ls;
  logic        dut_if_g;
  int          vectors = 0;
  int          miscompares = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int size_of(input logic [2:0] op);
    return 1 << op[1:0];
  endfunction

  function automatic logic [63:0] ref_load(input int a, input logic [2:0] op);
    int n;
    logic [63:0] v;
    n = size_of(op);
    v = '0;
    for (int i = n - 1; i >= 0; i--) v = (v << 8) | 64'(ref_b[a + i]);
    if (!op[2] && n < 8 && v[8*n-1]) v = v | ({64{1'b1}} << (8 * n));
    return v;
  endfunction

  task automatic reset_model();
    exp_if_v  = 1'b0;
    exp_ls_v  = 1'b0;
    exp_ls_e  = 1'b0;
    ls_streak = 0;
    favor_if  = 1'b1;
  endtask

  task automatic outputs_zero(input string tag);
    chk({tag, "_if_gnt"}, if_gnt_o, 0);
    chk({tag, "_if_rvalid"}, if_rvalid_o, 0);
    chk({tag, "_if_rdata"}, if_rdata_o, 0);
    chk({tag, "_ls_gnt"}, ls_gnt_o, 0);
    chk({tag, "_ls_rvalid"}, ls_rvalid_o, 0);
    chk({tag, "_ls_rdata"}, ls_rdata_o, 0);
    chk({tag, "_ls_err"}, ls_err_o, 0);
    chk({tag, "_mem_en"}, mem_en_o, 0);
    chk({tag, "_mem_we"}, mem_we_o, 0);
    chk({tag, "_mem_addr"}, mem_addr_o, 0);
    chk({tag, "_mem_wdata"}, mem_wdata_o, 0);
    chk({tag, "_mem_wstrb"}, mem_wstrb_o, 0);
  endtask

  // Compare this cycle's outputs with the model, then advance the model.
  task automatic check_cycle();
    bit g_if, g_ls;
    int a, n;
    logic [7:0] m;
    chk("if_rvalid", if_rvalid_o, exp_if_v);
    chk("if_rdata", if_rdata_o, exp_if_v ? exp_if_d : 32'h0);
    chk("ls_rvalid", ls_rvalid_o, exp_ls_v);
    chk("ls_err", ls_err_o, exp_ls_v & exp_ls_e);
    chk("ls_rdata", ls_rdata_o, exp_ls_v ? exp_ls_d : 64'h0);
    g_if = 1'b0;
    g_ls = 1'b0;
    if (rst_n) begin
`ifdef MEM_ARB_RR_EN
      if (if_req_i && ls_req_i) begin
        g_if = favor_if;
        g_ls = !favor_if;
      end else begin
        g_if = if_req_i;
        g_ls = ls_req_i;
      end
`else
      if (if_req_i && ls_req_i) g_ls = (ls_streak < STARVE_MAX);
      else                      g_ls = ls_req_i;
      g_if = if_req_i && !g_ls;
`endif
    end
    dut_if_g = if_gnt_o;
    chk("if_gnt", if_gnt_o, g_if);
    chk("ls_gnt", ls_gnt_o, g_ls);
    exp_if_v = g_if;
    exp_ls_v = g_ls;
    exp_ls_e = 1'b0;
    exp_ls_d = '0;
    if (g_if) begin
      a = int'(if_addr_i[31:0]) & (NBYTES - 4);
      exp_if_d = {ref_b[a+3], ref_b[a+2], ref_b[a+1], ref_b[a]};
      chk("if_mem_en", mem_en_o, 1);
      chk("if_mem_we", mem_we_o, 0);
      chk("if_mem_addr", mem_addr_o, 64'(a >> 3));
    end
    if (g_ls) begin
      a = int'(ls_addr_i[31:0]) & (NBYTES - 1);
      n = size_of(ls_memop_i);
      if (a % n != 0) begin
        exp_ls_e = 1'b1;
        chk("mis_mem_en", mem_en_o, 0);
      end else begin
        chk("ls_mem_en", mem_en_o, 1);
        chk("ls_mem_addr", mem_addr_o, 64'(a >> 3));
        chk("ls_mem_we", mem_we_o, ls_we_i);
        if (ls_we_i) begin
          m = 8'(((1 << n) - 1) << (a % 8));
          chk("st_strb", mem_wstrb_o, m);
          for (int i = 0; i < n; i++) ref_b[a + i] = ls_wdata_i[8*i +: 8];
        end else begin
          chk("ld_strb", mem_wstrb_o, 0);
          exp_ls_d = ref_load(a, ls_memop_i);
        end
      end
    end
    if (!g_if && !g_ls) chk("idle_mem_en", mem_en_o, 0);
    if (g_if || g_ls) favor_if = g_ls;
    if (!if_req_i || g_if) ls_streak = 0;
    else if (g_ls)         ls_streak++;
    saw_if = g_if;
    saw_ls = g_ls;
  endtask

  task automatic cycle();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic poke(input int w, input logic [63:0] v);
    poke_en  = 1'b1;
    poke_idx = DEPTH_LOG2'(w);
    poke_val = v;
    for (int i = 0; i < 8; i++) ref_b[w*8 + i] = v[8*i +: 8];
    cycle();
    poke_en = 1'b0;
  endtask

  task automatic ls_op(input bit we, input logic [2:0] op, input logic [63:0] addr,
                       input logic [63:0] d);
    ls_req_i   = 1'b1;
    ls_we_i    = we;
    ls_memop_i = op;
    ls_addr_i  = addr;
    ls_wdata_i = d;
  endtask

  logic [7:0] pattern;
  logic [2:0] op;
  int         sz, off;

  initial begin
    reset_model();
    saw_if = 1'b0;
    saw_ls = 1'b0;
    #1;
    outputs_zero("reset");
    for (int w = 0; w < NWORDS; w++) poke(w, {$urandom, $urandom});
    rst_n = 1'b1;
    cycle();

    // lw sign extension from the upper half of a word
    poke(2, 64'h8000_0001_1234_5678);
    ls_op(1'b0, MEMOP_W, 64'h14, 64'h0);
    cycle();
    ls_req_i = 1'b0;
    chk("t1_gnt", dut_if_g, 0);
    chk("t1_lw", ls_rdata_o, 64'hFFFF_FFFF_8000_0001);
    cycle();

    // sb into byte 3 of word 4, then read the word back
    poke(4, 64'h1122_3344_5566_7788);
    ls_op(1'b1, MEMOP_B, 64'h23, 64'hAB);
    #1;
    chk("t2_strb", mem_wstrb_o, 8'h08);
    chk("t2_addr", mem_addr_o, 4);
    cycle();
    ls_op(1'b0, MEMOP_D, 64'h20, 64'h0);
    cycle();
    ls_req_i = 1'b0;
    chk("t2_ld", ls_rdata_o, 64'h1122_3344_AB66_7788);
    cycle();

    // both ports requesting continuously
    if_req_i  = 1'b1;
    if_addr_i = 64'h0;
    ls_op(1'b0, MEMOP_D, 64'h8, 64'h0);
    pattern = '0;
    for (int k = 0; k < 8; k++) begin
      cycle();
      pattern[k] = dut_if_g;
    end
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
`ifdef MEM_ARB_RR_EN
    chk("t3_pattern", pattern, 8'h55);
`else
    chk("t3_pattern", pattern, 8'h88);
`endif
    cycle();

    // misaligned halfword load
    ls_op(1'b0, MEMOP_H, 64'h101, 64'h0);
    #1;
    chk("t4_gnt", ls_gnt_o, 1);
    chk("t4_en", mem_en_o, 0);
    cycle();
    ls_req_i = 1'b0;
    chk("t4_rvalid", ls_rvalid_o, 1);
    chk("t4_err", ls_err_o, 1);
    chk("t4_rdata", ls_rdata_o, 0);
    cycle();

    // back-to-back fetches from both halves of word 0
    poke(0, 64'h0000_0013_0010_0093);
    if_req_i  = 1'b1;
    if_addr_i = 64'h0;
    cycle();
    if_addr_i = 64'h4;
    chk("t5_v0", if_rvalid_o, 1);
    chk("t5_d0", if_rdata_o, 32'h0010_0093);
    cycle();
    if_req_i = 1'b0;
    chk("t5_v1", if_rvalid_o, 1);
    chk("t5_d1", if_rdata_o, 32'h0000_0013);
    cycle();

    // reset asserted while an ld response is due
    ls_op(1'b0, MEMOP_D, 64'h8, 64'h0);
    cycle();
    ls_req_i = 1'b0;
    rst_n = 1'b0;
    reset_model();
    #1;
    chk("t6_rvalid", ls_rvalid_o, 0);
    cycle();
    cycle();
    rst_n = 1'b1;
    #1;
    outputs_zero("t6_post");
    cycle();

    // randomized traffic, requests held until granted
    for (int k = 0; k < 3000; k++) begin
      if (!if_req_i || saw_if) begin
        if_req_i  = ($urandom_range(0, 2) != 0);
        if_addr_i = {32'h0, $urandom};
      end
      if (!ls_req_i || saw_ls) begin
        ls_req_i = ($urandom_range(0, 2) != 0);
        ls_we_i  = ($urandom_range(0, 2) == 0);
        op = ls_we_i ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
        sz = size_of(op);
        if ($urandom_range(0, 7) == 0) off = $urandom_range(0, 7);
        else                           off = $urandom_range(0, 8 / sz - 1) * sz;
        ls_memop_i = op;
        ls_addr_i  = {32'h0, $urandom};
        ls_addr_i[2:0] = 3'(off);
        ls_wdata_i = {$urandom, $urandom};
      end
      cycle();
    end
    if_req_i = 1'b0;
    ls_req_i = 1'b0;
    cycle();
    cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
